// File: rtl/axis_frame_normalizer_if.sv
// AXI4-Stream video bus bundle (pixel data, valid/ready handshake,
// tlast = end of line, tuser = start of frame).
// master modport: drives tdata/tvalid/tlast/tuser, samples tready.
// slave modport:  samples tdata/tvalid/tlast/tuser, drives tready.
interface axis_frame_normalizer_if #(
    parameter int DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_frame_normalizer.sv
// Re-times camera AXI4-Stream video into strictly well-formed frames of
// exactly H_ACTIVE x V_ACTIVE pixels: short lines are padded with PAD_VALUE,
// long lines are truncated, and data before SOF or after the last line is
// dropped. Output is a single register stage with one-cycle latency.
// Ports:
//   axis_clk, aresetn  clock and asynchronous active-low reset
//   s_axis             input video stream (slave modport)
//   m_axis             normalized output stream (master modport)
//   frame_count        completed output frames, wraps
//   err_*              one-cycle fault pulses, on the cycle the causing beat
//                      is consumed
module axis_frame_normalizer #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    H_ACTIVE   = 1280,
    parameter int                    V_ACTIVE   = 1024,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,
    axis_frame_normalizer_if.slave          s_axis,
    axis_frame_normalizer_if.master         m_axis,
    output logic [CNT_WIDTH-1:0]            frame_count,
    output logic                            err_short_line,
    output logic                            err_long_line,
    output logic                            err_short_frame,
    output logic                            err_long_frame
);

    typedef enum logic [2:0] {
        S_WAIT_SOF,
        S_ACTIVE,
        S_PAD,
        S_DISCARD,
        S_DRAIN
    } state_t;

    localparam logic [CNT_WIDTH-1:0] X_LAST = CNT_WIDTH'(H_ACTIVE - 1);
    localparam logic [CNT_WIDTH-1:0] Y_LAST = CNT_WIDTH'(V_ACTIVE - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [CNT_WIDTH-1:0] cx, cy;
    logic                 drain_err_q, drain_err_d;
    logic                 ready_en_q;
    logic                 out_free, beat, take_pixel;
    logic                 load, load_last, load_user, frame_done;
    logic [DATA_WIDTH-1:0] load_data;

    assign out_free = ~m_axis.tvalid | m_axis.tready;
    // ready_en_q keeps s_axis.tready low while in reset (out_free alone is 1 there).
    assign s_axis.tready = ready_en_q & out_free & (state_q != S_PAD);
    assign beat = s_axis.tvalid & s_axis.tready;

    // Next-state / output-load decision.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        cx              = x_q;
        cy              = y_q;
        drain_err_d     = (state_q == S_DRAIN) & drain_err_q;
        take_pixel      = 1'b0;
        load            = 1'b0;
        load_data       = s_axis.tdata;
        load_last       = 1'b0;
        load_user       = 1'b0;
        frame_done      = 1'b0;
        err_short_line  = 1'b0;
        err_long_line   = 1'b0;
        err_short_frame = 1'b0;
        err_long_frame  = 1'b0;

        if (beat) begin
            if (s_axis.tuser) begin
                // SOF always restarts at (0,0); mid-frame it truncates the frame.
                if ((state_q == S_ACTIVE || state_q == S_DISCARD) &&
                    (x_q != '0 || y_q != '0))
                    err_short_frame = 1'b1;
                cx         = '0;
                cy         = '0;
                load_user  = 1'b1;
                take_pixel = 1'b1;
            end else begin
                case (state_q)
                    S_ACTIVE:  take_pixel = 1'b1;
                    S_DISCARD: if (s_axis.tlast) state_d = S_ACTIVE;
                    S_DRAIN: begin
                        if (!drain_err_q) begin
                            err_long_frame = 1'b1;
                            drain_err_d    = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            // Pixel placed at (cx,cy); tuser was handled above, tlast here.
            if (take_pixel) begin
                load      = 1'b1;
                load_last = (cx == X_LAST);
                if (cx == X_LAST) begin
                    err_long_line = ~s_axis.tlast;
                    x_d           = '0;
                    if (cy == Y_LAST) begin
                        y_d         = '0;
                        frame_done  = 1'b1;
                        state_d     = S_DRAIN;
                        drain_err_d = 1'b0;
                    end else begin
                        y_d     = cy + 1'b1;
                        state_d = s_axis.tlast ? S_ACTIVE : S_DISCARD;
                    end
                end else begin
                    x_d = cx + 1'b1;
                    y_d = cy;
                    if (s_axis.tlast) begin
                        err_short_line = 1'b1;
                        state_d        = S_PAD;
                    end else begin
                        state_d = S_ACTIVE;
                    end
                end
            end
        end else if (state_q == S_PAD && out_free) begin
            load      = 1'b1;
            load_data = PAD_VALUE;
            load_last = (x_q == X_LAST);
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d         = '0;
                    frame_done  = 1'b1;
                    state_d     = S_DRAIN;
                    drain_err_d = 1'b0;
                end else begin
                    y_d     = y_q + 1'b1;
                    state_d = S_ACTIVE;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            drain_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            drain_err_q <= drain_err_d;
            ready_en_q  <= 1'b1;
            if (frame_done)
                frame_count <= frame_count + 1'b1;
        end
    end

    // Output register: holds its beat while tvalid & ~tready.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tlast  <= 1'b0;
            m_axis.tuser  <= 1'b0;
        end else if (out_free) begin
            m_axis.tvalid <= load;
            if (load) begin
                m_axis.tdata <= load_data;
                m_axis.tlast <= load_last;
                m_axis.tuser <= load_user;
            end
        end
    end

endmodule

// File: tb/tb_axis_frame_normalizer.sv
// Self-checking bench for axis_frame_normalizer (H=8, V=4, PAD=0).
// A frame-level reference model turns every accepted input beat into the
// expected output beats (including pad runs) and error counts; the DUT output
// stream, error pulse counts and frame_count are compared against it.
module tb_axis_frame_normalizer;
    localparam int DW = 24;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int CW = 16;

    typedef enum int {M_WAIT, M_LINE, M_DISCARD, M_DRAIN} mode_t;

    logic axis_clk = 1'b0;
    logic aresetn  = 1'b0;
    always #5 axis_clk = ~axis_clk;

    axis_frame_normalizer_if #(.DATA_WIDTH(DW)) s_if ();
    axis_frame_normalizer_if #(.DATA_WIDTH(DW)) m_if ();

    logic [CW-1:0] frame_count;
    logic err_short_line, err_long_line, err_short_frame, err_long_frame;

    axis_frame_normalizer #(
        .DATA_WIDTH(DW), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_WIDTH(CW), .PAD_VALUE('0)
    ) dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .frame_count     (frame_count),
        .err_short_line  (err_short_line),
        .err_long_line   (err_long_line),
        .err_short_frame (err_short_frame),
        .err_long_frame  (err_long_frame)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    mode_t           md_mode = M_WAIT;
    int              mx = 0, my = 0;
    bit              md_drain_err = 0;
    int              exp_frames = 0;
    int              exp_sl = 0, exp_ll = 0, exp_sf = 0, exp_lf = 0;
    logic [DW+1:0]   exp_q[$];

    int              got_sl = 0, got_ll = 0, got_sf = 0, got_lf = 0;
    bit              bp_en = 0;

    task automatic push_exp(input logic [DW-1:0] d, input logic last, input logic user);
        exp_q.push_back({user, last, d});
    endtask

    task automatic model_end_line();
        mx = 0;
        my++;
        if (my == V) begin
            my = 0;
            exp_frames++;
            md_mode = M_DRAIN;
            md_drain_err = 0;
        end
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic l, input logic u);
        bit px = 0;
        if (u) begin
            if ((md_mode == M_LINE || md_mode == M_DISCARD) && (mx != 0 || my != 0))
                exp_sf++;
            mx = 0; my = 0; md_mode = M_LINE; px = 1;
        end else begin
            case (md_mode)
                M_LINE:    px = 1;
                M_DISCARD: if (l) md_mode = M_LINE;
                M_DRAIN:   if (!md_drain_err) begin exp_lf++; md_drain_err = 1; end
                default: ;
            endcase
        end
        if (px) begin
            if (mx == H - 1) begin
                push_exp(d, 1'b1, u);
                if (!l) begin exp_ll++; md_mode = M_DISCARD; end
                else md_mode = M_LINE;
                model_end_line();
            end else if (l) begin
                push_exp(d, 1'b0, u);
                exp_sl++;
                for (int i = mx + 1; i < H; i++) push_exp('0, (i == H - 1), 1'b0);
                md_mode = M_LINE;
                model_end_line();
            end else begin
                push_exp(d, 1'b0, u);
                mx++;
            end
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge axis_clk) begin
        if (aresetn) begin
            if (m_if.tvalid && m_if.tready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0)
                    check("out_beat", 64'({m_if.tuser, m_if.tlast, m_if.tdata}), 64'(exp_q.pop_front()));
            end
            got_sl += int'(err_short_line);
            got_ll += int'(err_long_line);
            got_sf += int'(err_short_frame);
            got_lf += int'(err_long_frame);
        end
    end

    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge axis_clk);
            #1;
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic u);
        bit got = 0;
        s_if.tdata = d; s_if.tlast = l; s_if.tuser = u; s_if.tvalid = 1'b1;
        for (int n = 0; n < 1000 && !got; n++) begin
            @(negedge axis_clk);
            if (s_if.tready) begin
                got = 1;
                model_beat(d, l, u);
            end
            @(posedge axis_clk);
            #1;
        end
        if (!got) check("send_timeout", 64'(got), 64'(1));
        s_if.tvalid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic send_line(input int len, input bit sof);
        for (int i = 0; i < len; i++)
            send_beat(DW'($urandom), (i == len - 1), sof && (i == 0));
    endtask

    task automatic send_frame();
        for (int l = 0; l < V; l++) send_line(H, l == 0);
    endtask

    task automatic drain_and_compare(input string tag);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge axis_clk);
        repeat (3) @(posedge axis_clk);
        #1;
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_frame_count"}, 64'(frame_count), 64'(exp_frames % 65536));
        check({tag, "_err_short_line"}, 64'(got_sl), 64'(exp_sl));
        check({tag, "_err_long_line"}, 64'(got_ll), 64'(exp_ll));
        check({tag, "_err_short_frame"}, 64'(got_sf), 64'(exp_sf));
        check({tag, "_err_long_frame"}, 64'(got_lf), 64'(exp_lf));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_if.tvalid), 64'(0));
        check({tag, "_m_tdata"}, 64'(m_if.tdata), 64'(0));
        check({tag, "_m_tlast_tuser"}, 64'({m_if.tlast, m_if.tuser}), 64'(0));
        check({tag, "_s_tready"}, 64'(s_if.tready), 64'(0));
        check({tag, "_frame_count"}, 64'(frame_count), 64'(0));
        check({tag, "_errs"}, 64'({err_short_line, err_long_line, err_short_frame, err_long_frame}), 64'(0));
    endtask

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        check_reset_values("reset");
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;

        // Clean frame
        send_frame();
        drain_and_compare("clean");
        check("clean_one_frame", 64'(frame_count), 64'(1));

        // Pre-SOF garbage then clean frame (5 garbage beats land in DRAIN)
        for (int i = 0; i < 5; i++) send_beat(DW'($urandom), 1'b0, 1'b0);
        send_frame();
        drain_and_compare("pre_sof");

        // Short line: line 1 only 5 beats
        send_line(H, 1); send_line(5, 0); send_line(H, 0); send_line(H, 0);
        drain_and_compare("short_line");

        // Long line (11 beats) plus surplus line before next SOF
        send_line(H, 1); send_line(H, 0); send_line(11, 0); send_line(H, 0);
        send_line(H, 0);
        send_frame();
        drain_and_compare("long_line");

        // Premature SOF at line 2 pixel 3
        send_line(H, 1); send_line(H, 0);
        for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 1'b0, 1'b0);
        send_frame();
        drain_and_compare("premature_sof");

        // SOF and tlast on the same beat
        send_beat(DW'($urandom), 1'b1, 1'b1);
        for (int l = 1; l < V; l++) send_line(H, 0);
        drain_and_compare("sof_tlast");

        // Backpressure during a clean frame
        bp_en = 1;
        send_frame();
        drain_and_compare("backpressure");

        // Reset at line 2
        send_line(H, 1); send_line(H, 0);
        for (int i = 0; i < 3; i++) send_beat(DW'($urandom), 1'b0, 1'b0);
        aresetn = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        md_mode = M_WAIT; mx = 0; my = 0; exp_frames = 0;
        repeat (2) @(posedge axis_clk);
        #1;
        aresetn = 1'b1;
        @(posedge axis_clk);
        #1;
        send_frame();
        drain_and_compare("after_reset");
        check("after_reset_one_frame", 64'(frame_count), 64'(1));

        // Random chaos with backpressure, then a clean frame
        for (int i = 0; i < 500; i++)
            send_beat(DW'($urandom), 1'($urandom_range(0, 8) == 0), 1'($urandom_range(0, 40) == 0));
        send_frame();
        drain_and_compare("random");
        bp_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
endmodule
